// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Purpose:
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Holds a 4-digit BCD value and steps through the digits at a fixed refresh
//   rate, driving the digit select (en) and nibble (num) inputs of the
//   SevenSegDecWithEn decoder. New values arrive over a valid/ready handshake.
//   While scanning, an accepted value is parked in a pending register and only
//   moved to the display register at a frame boundary. A frame therefore never
//   mixes old and new digits.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 1)
//   LEAD_BLANK   1 = blank leading zeros on digits 3..1, 0 = show all digits
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   load_valid   in   1   value is offered this cycle
//   load_ready   out  1   controller can accept a value this cycle
//   value        in   16  BCD digits, [3:0]=digit0 ... [15:12]=digit3
//   blank        in   1   1 = force num=4'hF while scanning continues
//   en           out  2   digit select to decoder
//   num          out  4   nibble to decoder, 4'hF = all segments off
//   frame_done   out  1   1-cycle pulse in the cycle after en wraps 3->0
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LEAD_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] value,
  input  logic        blank,
  output logic [1:0]  en,
  output logic [3:0]  num,
  output logic        frame_done
);

  // A divide-by-1 still needs a 1-bit counter so that the compare is legal.
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [3:0] NUM_OFF = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t          state_q,        state_d;
  logic [CW-1:0]   count_q,        count_d;
  logic [1:0]      en_q,           en_d;
  logic [15:0]     display_q,      display_d;
  logic [15:0]     pending_q,      pending_d;
  logic            pending_full_q, pending_full_d;
  logic            load_ready_q,   load_ready_d;
  logic            frame_done_q,   frame_done_d;

  logic            accept;
  logic            tick;
  logic            boundary;

  assign accept   = load_valid & load_ready_q;
  assign tick     = (count_q == COUNT_MAX);
  // The tick that moves en from 3 back to 0 closes the current frame.
  assign boundary = tick & (en_q == 2'd3);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    en_d           = en_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_done_d   = 1'b0;

    unique case (state_q)
      ST_BLANK: begin
        // Idle: divider and digit select are parked so that scanning starts
        // with a full digit-0 slot on the cycle after the first accept.
        count_d = '0;
        en_d    = 2'd0;
        if (accept) begin
          display_d = value;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        count_d = tick ? '0 : count_q + 1'b1;
        if (tick) begin
          en_d = en_q + 2'd1;
        end
        if (boundary) begin
          frame_done_d = 1'b1;
          // pending_full_q only rises the cycle after an accept, so a value
          // accepted on a boundary tick naturally waits for the next frame.
          if (pending_full_q) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
          end
        end
        // Accept and commit cannot coincide: accept needs load_ready_q, which
        // is low for as long as pending_full_q is high.
        if (accept) begin
          pending_d      = value;
          pending_full_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_BLANK;
      end
    endcase

    load_ready_d = ~pending_full_d;
  end

  // ---------------------------------------------------------------------------
  // Registers (single sequential block, synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BLANK;
      count_q        <= '0;
      en_q           <= 2'd0;
      display_q      <= 16'h0000;
      pending_q      <= 16'h0000;
      pending_full_q <= 1'b0;
      load_ready_q   <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      en_q           <= en_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      load_ready_q   <= load_ready_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and leading-zero detection
  // ---------------------------------------------------------------------------
  // digit_c[k]   : nibble k of the display register
  // zero_up_c[k] : digits k..3 are all zero (candidate for leading blank)
  logic [3:0] digit_c [4];
  logic [3:0] zero_up_c;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_c[gi]   = display_q[4*gi +: 4];
      assign zero_up_c[gi] = (display_q[15:4*gi] == '0);
    end
  endgenerate

  logic [3:0] num_c;

  always_comb begin
    num_c = digit_c[en_q];
    if ((state_q == ST_BLANK) || blank) begin
      num_c = NUM_OFF;
    end else if (LEAD_BLANK && (en_q != 2'd0) && zero_up_c[en_q]) begin
      // Digit 0 is never blanked so a zero value still shows a single "0".
      num_c = NUM_OFF;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: en, load_ready and frame_done are registered; num follows the
  // registered en in the same cycle with no extra latency.
  // ---------------------------------------------------------------------------
  assign en         = en_q;
  assign num        = num_c;
  assign load_ready = load_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the REFRESH_DIV=4 instances (LEAD_BLANK=1 and 0)
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        blank = 1'b0;

  logic        load_ready, frame_done;
  logic [1:0]  en;
  logic [3:0]  num;
  logic        ready_nb, fd_nb;
  logic [1:0]  en_nb;
  logic [3:0]  num_nb;

  // Separate stimulus for the REFRESH_DIV=1 instance
  logic        rst1 = 1'b1;
  logic        lv1 = 1'b0;
  logic [15:0] value1 = 16'h0000;
  logic        blank1 = 1'b0;
  logic        ready1, fd1;
  logic [1:0]  en1;
  logic [3:0]  num1;

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .LEAD_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .value(value), .blank(blank), .en(en), .num(num), .frame_done(frame_done));

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .LEAD_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_nb),
    .value(value), .blank(blank), .en(en_nb), .num(num_nb), .frame_done(fd_nb));

  seven_seg_scan_ctrl #(.REFRESH_DIV(1), .LEAD_BLANK(1'b1)) dut_d1 (
    .clk(clk), .rst(rst1), .load_valid(lv1), .load_ready(ready1),
    .value(value1), .blank(blank1), .en(en1), .num(num1), .frame_done(fd1));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are held for ncyc rising edges, then outputs are compared 1 time
  // unit after the last edge.
  typedef struct {
    logic        rst;
    logic        lv;
    logic [15:0] value;
    logic        blank;
    int          ncyc;
    logic [1:0]  en;
    logic [3:0]  num;
    logic [3:0]  num_nb;
    logic        rdy;
    logic        fd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic lv, input logic [15:0] v,
                              input logic b, input int n, input logic [1:0] e,
                              input logic [3:0] nm, input logic [3:0] nb,
                              input logic rdy, input logic fd);
    vec_t t;
    t.rst = r; t.lv = lv; t.value = v; t.blank = b; t.ncyc = n;
    t.en = e; t.num = nm; t.num_nb = nb; t.rdy = rdy; t.fd = fd;
    return t;
  endfunction

  initial begin
    // ---------------- Hand sequence: reset then idle 20 cycles ----------------
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d.en", c), en, 0);
      chk($sformatf("idle%0d.num", c), num, 4'hF);
      chk($sformatf("idle%0d.rdy", c), load_ready, 1);
      chk($sformatf("idle%0d.fd", c), frame_done, 0);
    end

    // ---------------- Vector table ----------------
    //                rst lv value    blk n   en num nb  rdy fd
    vq.push_back(mk(1, 0, 16'h0000, 0, 2,  0, 'hF, 'hF, 1, 0)); // reset
    vq.push_back(mk(0, 0, 16'h0000, 0, 3,  0, 'hF, 'hF, 1, 0)); // idle
    vq.push_back(mk(0, 1, 16'h1234, 0, 1,  0, 'h4, 'h4, 1, 0)); // load in BLANK
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'h3, 'h3, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'h2, 'h2, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'h1, 'h1, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  0, 'h4, 'h4, 1, 1)); // wrap pulse
    vq.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 'h4, 'h4, 1, 0)); // pulse ends
    vq.push_back(mk(0, 0, 16'h0000, 0, 3,  1, 'h3, 'h3, 1, 0));
    vq.push_back(mk(0, 1, 16'h0056, 0, 1,  1, 'h3, 'h3, 0, 0)); // accept at en=1
    vq.push_back(mk(0, 0, 16'h0000, 0, 3,  2, 'h2, 'h2, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'h1, 'h1, 0, 0));
    vq.push_back(mk(0, 1, 16'h9999, 0, 1,  3, 'h1, 'h1, 0, 0)); // ignored offer
    vq.push_back(mk(0, 0, 16'h0000, 0, 2,  3, 'h1, 'h1, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 'h6, 'h6, 1, 1)); // commit 0056
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'h5, 'h5, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 3,  3, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 1, 16'h0789, 0, 1,  0, 'h6, 'h6, 0, 1)); // accept on boundary tick
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'h5, 'h5, 0, 0)); // old frame again
    vq.push_back(mk(0, 0, 16'h0000, 0, 8,  3, 'hF, 'h0, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  0, 'h9, 'h9, 1, 1)); // commit 0789
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'h8, 'h8, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'h7, 'h7, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 1, 16'h0000, 0, 1,  3, 'hF, 'h0, 0, 0)); // load 0000
    vq.push_back(mk(0, 0, 16'h0000, 0, 3,  0, 'h0, 'h0, 1, 1));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 4,  0, 'hF, 'hF, 1, 1)); // blank, still stepping
    vq.push_back(mk(0, 0, 16'h0000, 1, 4,  1, 'hF, 'hF, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'hF, 'h0, 1, 0));
    vq.push_back(mk(0, 1, 16'h4321, 0, 1,  2, 'hF, 'h0, 0, 0)); // pending 4321
    vq.push_back(mk(1, 0, 16'h0000, 0, 1,  0, 'hF, 'hF, 1, 0)); // rst mid-scan
    vq.push_back(mk(0, 0, 16'h0000, 0, 20, 0, 'hF, 'hF, 1, 0)); // pending dropped
    vq.push_back(mk(0, 1, 16'h5008, 0, 1,  0, 'h8, 'h8, 1, 0)); // BLANK path again
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  1, 'h0, 'h0, 1, 0)); // inner zero shown
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  2, 'h0, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  3, 'h5, 'h5, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 4,  0, 'h8, 'h8, 1, 1));

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst        = vq[i].rst;
      load_valid = vq[i].lv;
      value      = vq[i].value;
      blank      = vq[i].blank;
      repeat (vq[i].ncyc) @(posedge clk);
      #1;
      chk($sformatf("v%0d.en", i), en, vq[i].en);
      chk($sformatf("v%0d.num", i), num, vq[i].num);
      chk($sformatf("v%0d.num_nb", i), num_nb, vq[i].num_nb);
      chk($sformatf("v%0d.rdy", i), load_ready, vq[i].rdy);
      chk($sformatf("v%0d.fd", i), frame_done, vq[i].fd);
      $display("vec %0d: en=%0d num=%h num_nb=%h rdy=%0d fd=%0d", i, en, num, num_nb,
               load_ready, frame_done);
    end

    // ---------------- Hand sequence: REFRESH_DIV=1 (tick every cycle) ----------
    begin
      logic [1:0] e_en  [8];
      logic [3:0] e_num [8];
      logic       e_rdy [8];
      logic       e_fd  [8];
      e_en  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      e_num = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
      e_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      e_fd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      rst1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("d1.rst.num", num1, 4'hF);
      rst1 = 1'b0; lv1 = 1'b1; value1 = 16'h1234;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        // Second offer (non-BCD digits) goes in while scanning; then stop.
        if (c == 0) value1 = 16'hABCD;
        else lv1 = 1'b0;
        chk($sformatf("d1.c%0d.en", c), en1, e_en[c]);
        chk($sformatf("d1.c%0d.num", c), num1, e_num[c]);
        chk($sformatf("d1.c%0d.rdy", c), ready1, e_rdy[c]);
        chk($sformatf("d1.c%0d.fd", c), fd1, e_fd[c]);
        $display("d1 cycle %0d: en=%0d num=%h rdy=%0d fd=%0d", c, en1, num1, ready1, fd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
